// File: rtl/fetch_queue.sv
// Instruction-fetch front end: sequential PC generation, 1-cycle ROM read, small FIFO to the Decoder.
// Optional FETCH_BYPASS_EN: an empty queue forwards a returning word combinationally.
module fetch_queue #(
    parameter int                   DBITS               = 32,
    parameter int                   INST_BIT_WIDTH      = 32,
    parameter logic [DBITS-1:0]     START_PC            = 32'h40,
    parameter logic [DBITS-1:0]     INST_SIZE           = 32'd4,
    parameter int                   IMEM_ADDR_BIT_WIDTH = 11,
    parameter int                   DEPTH               = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    output logic                           imemReq,
    output logic [IMEM_ADDR_BIT_WIDTH-1:0] imemAddr,
    input  logic [INST_BIT_WIDTH-1:0]      imemData,
    input  logic                           redirect,
    input  logic [DBITS-1:0]               redirectPc,
    output logic                           instValid,
    input  logic                           instReady,
    output logic [INST_BIT_WIDTH-1:0]      instWord,
    output logic [DBITS-1:0]               instPc,
    output logic [$clog2(DEPTH):0]         occupancy
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DBITS-1:0]          r_fetchPc;
    logic [DBITS-1:0]          r_reqPc;
    logic                      r_pending;
    logic [CW-1:0]             r_count;
    logic [PW-1:0]             r_rdPtr;
    logic [PW-1:0]             r_wrPtr;
    logic [INST_BIT_WIDTH-1:0] r_memWord [DEPTH];
    logic [DBITS-1:0]          r_memPc   [DEPTH];

    logic [CW:0] w_inUse;
    logic        w_issue;
    logic        w_ret;
    logic        w_bypass;
    logic        w_fifoValid;
    logic        w_pop;
    logic        w_popFifo;
    logic        w_push;

    // Credit = stored entries plus the word still in flight, so a return always has a slot.
    assign w_inUse     = {1'b0, r_count} + {{CW{1'b0}}, r_pending};
    assign w_issue     = !reset && !redirect && (w_inUse < (CW+1)'(DEPTH));
    assign w_ret       = r_pending && !redirect;
    assign w_fifoValid = (r_count != '0);

`ifdef FETCH_BYPASS_EN
    assign w_bypass = w_ret && (r_count == '0);
`else
    assign w_bypass = 1'b0;
`endif

    assign instValid = w_fifoValid || w_bypass;
    assign w_pop     = instValid && instReady;
    assign w_popFifo = w_pop && w_fifoValid;
    assign w_push    = w_ret && !(w_bypass && instReady);

    always_comb begin
        instWord = '0;
        instPc   = '0;
        if (w_fifoValid) begin
            instWord = r_memWord[r_rdPtr];
            instPc   = r_memPc[r_rdPtr];
        end else if (w_bypass) begin
            instWord = imemData;
            instPc   = r_reqPc;
        end
    end

    assign imemReq   = w_issue;
    assign imemAddr  = r_fetchPc[IMEM_ADDR_BIT_WIDTH+1:2];
    assign occupancy = r_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fetchPc <= START_PC;
            r_reqPc   <= '0;
            r_pending <= 1'b0;
            r_count   <= '0;
            r_rdPtr   <= '0;
            r_wrPtr   <= '0;
        end else if (redirect) begin
            // A same-cycle pop is the branch itself; everything younger is dropped.
            r_fetchPc <= redirectPc & ~DBITS'(3);
            r_pending <= 1'b0;
            r_count   <= '0;
            r_rdPtr   <= '0;
            r_wrPtr   <= '0;
        end else begin
            r_pending <= w_issue;
            if (w_issue) begin
                r_reqPc   <= r_fetchPc;
                r_fetchPc <= r_fetchPc + INST_SIZE;
            end
            if (w_push)
                r_wrPtr <= r_wrPtr + PW'(1);
            if (w_popFifo)
                r_rdPtr <= r_rdPtr + PW'(1);
            r_count <= r_count + CW'(w_push) - CW'(w_popFifo);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && w_push) begin
            r_memWord[r_wrPtr] <= imemData;
            r_memPc[r_wrPtr]   <= r_reqPc;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Randomized bench for fetch_queue against a queue-based reference model and a program-order scoreboard.
module tb_fetch_queue;
    localparam int          DEPTH = 4;
    localparam logic [31:0] START = 32'h40;
`ifdef FETCH_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1, redirect = 1'b0, instReady = 1'b0;
    logic [31:0] redirectPc = '0;
    logic        imemReq, instValid;
    logic [10:0] imemAddr;
    logic [31:0] imemData = '0, instWord, instPc;
    logic [2:0]  occupancy;

    fetch_queue dut (
        .clk(clk), .reset(reset), .imemReq(imemReq), .imemAddr(imemAddr),
        .imemData(imemData), .redirect(redirect), .redirectPc(redirectPc),
        .instValid(instValid), .instReady(instReady), .instWord(instWord),
        .instPc(instPc), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    logic [31:0] rom [2048];
    // ROM answers one cycle after a request; unrequested cycles return junk.
    always @(posedge clk) imemData <= imemReq ? rom[imemAddr] : $urandom();

    typedef struct { logic [31:0] w; logic [31:0] pc; } ent_t;
    ent_t        q[$];
    bit          m_pend = 1'b0, chk_en = 1'b0;
    logic [31:0] m_reqPc = '0, m_fetchPc = START, exp_seq = START;
    int          checks = 0, failures = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, compare against the model, advance the model.
    task automatic step(input bit r, input bit rd, input logic [31:0] rpc, input bit rdy);
        bit   issue, ret, byp, valid, pop;
        int   n;
        ent_t head, rtn;
        reset = r; redirect = rd; redirectPc = rpc; instReady = rdy;
        #1;
        n     = q.size();
        issue = !r && !rd && (n + int'(m_pend) < DEPTH);
        ret   = m_pend && !rd;
        byp   = BYP && n == 0 && ret;
        valid = n > 0 || byp;
        rtn   = '{w: imemData, pc: m_reqPc};
        head  = (n > 0) ? q[0] : rtn;
        pop   = valid && rdy;
        if (chk_en) begin
            chk("imemReq", 64'(imemReq), 64'(issue));
            if (issue) chk("imemAddr", 64'(imemAddr), 64'(m_fetchPc[12:2]));
            chk("instValid", 64'(instValid), 64'(valid));
            chk("instWord", 64'(instWord), valid ? 64'(head.w) : 64'h0);
            chk("instPc", 64'(instPc), valid ? 64'(head.pc) : 64'h0);
            chk("occupancy", 64'(occupancy), 64'(n));
            if (pop && !r) begin
                chk("seqPc", 64'(instPc), 64'(exp_seq));
                chk("seqWord", 64'(instWord), 64'(rom[exp_seq[12:2]]));
                exp_seq = exp_seq + 32'd4;
            end
        end
        @(posedge clk);
        if (r) begin
            q.delete(); m_pend = 1'b0; m_fetchPc = START; exp_seq = START;
        end else if (rd) begin
            q.delete(); m_pend = 1'b0;
            m_fetchPc = rpc & ~32'd3; exp_seq = rpc & ~32'd3;
        end else begin
            if (pop && n > 0) void'(q.pop_front());
            if (ret && !(byp && rdy)) q.push_back(rtn);
            m_pend = issue;
            if (issue) begin
                m_reqPc   = m_fetchPc;
                m_fetchPc = m_fetchPc + 32'd4;
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, '0, 1'b0);
    endtask

    initial begin
        int first;
        for (int i = 0; i < 2048; i++) rom[i] = $urandom();
        rom[11'h10] = 32'h80660009;
        @(negedge clk);
        step(1'b1, 1'b0, '0, 1'b0);
        chk_en = 1'b1;
        do_reset();

        // First fetch address and fill latency
        reset = 1'b0; redirect = 1'b0; instReady = 1'b1;
        #1;
        chk("first_addr", 64'(imemAddr), 64'h10);
        chk("first_req", 64'(imemReq), 64'h1);
        first = -1;
        for (int c = 0; c < 4; c++) begin
            reset = 1'b0; redirect = 1'b0; instReady = 1'b1;
            #1;
            if (instValid && first < 0) first = c;
            step(1'b0, 1'b0, '0, 1'b1);
        end
        chk("latency", 64'(first), BYP ? 64'd1 : 64'd2);
        for (int c = 0; c < 8; c++) step(1'b0, 1'b0, '0, 1'b1);

        // Stall until full, then drain in order
        do_reset();
        for (int c = 0; c < 10; c++) step(1'b0, 1'b0, '0, 1'b0);
        chk("full_occ", 64'(occupancy), 64'd4);
        chk("full_noreq", 64'(imemReq), 64'h0);
        for (int c = 0; c < 10; c++) step(1'b0, 1'b0, '0, 1'b1);

        // Redirect with 3 buffered and one in flight
        do_reset();
        for (int c = 0; c < 4; c++) step(1'b0, 1'b0, '0, 1'b0);
        chk("pre_redir_occ", 64'(occupancy), 64'd3);
        step(1'b0, 1'b1, 32'h233, 1'b0);
        redirect = 1'b0;
        #1;
        chk("redir_occ", 64'(occupancy), 64'd0);
        chk("redir_valid", 64'(instValid), 64'h0);
        chk("redir_addr", 64'(imemAddr), 64'h8C);
        for (int c = 0; c < 6; c++) step(1'b0, 1'b0, '0, 1'b1);

        // Redirect with a same-cycle pop
        do_reset();
        for (int c = 0; c < 4; c++) step(1'b0, 1'b0, '0, 1'b0);
        step(1'b0, 1'b1, 32'h100, 1'b1);
        for (int c = 0; c < 6; c++) step(1'b0, 1'b0, '0, 1'b1);

        // Reset mid-stream with 3 buffered
        do_reset();
        for (int c = 0; c < 4; c++) step(1'b0, 1'b0, '0, 1'b0);
        step(1'b1, 1'b0, '0, 1'b1);
        #1;
        chk("rst_valid", 64'(instValid), 64'h0);
        chk("rst_word", 64'(instWord), 64'h0);
        chk("rst_pc", 64'(instPc), 64'h0);
        chk("rst_occ", 64'(occupancy), 64'h0);
        for (int c = 0; c < 6; c++) step(1'b0, 1'b0, '0, 1'b1);

        // PC wrap at the top of the address space
        step(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1);
        redirect = 1'b0;
        #1;
        chk("wrap_addr0", 64'(imemAddr), 64'h7FF);
        step(1'b0, 1'b0, '0, 1'b1);
        #1;
        chk("wrap_addr1", 64'(imemAddr), 64'h0);
        for (int c = 0; c < 6; c++) step(1'b0, 1'b0, '0, 1'b1);

        // Randomized traffic
        for (int c = 0; c < 1500; c++) begin
            bit          r, rd, rdy;
            logic [31:0] rpc;
            r   = ($urandom_range(0, 199) == 0);
            rd  = ($urandom_range(0, 19) == 0);
            rdy = ($urandom_range(0, 9) < 7);
            rpc = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                             : $urandom();
            step(r, rd, rpc, rdy);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
